// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, ALUOp encodings and R-type funct codes shared by the ALU and its issue stage
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// fwd_mux: picks the newest value of one source register from EX/MEM, MEM/WB or the register file
//   i_idx                              source register index
//   i_rf_data                          register-file read data
//   i_exmem_we/_rd/_data               EX/MEM write-back (takes priority, it is newer)
//   i_memwb_we/_rd/_data               MEM/WB write-back
//   o_data                             forwarded operand
module fwd_mux #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic [REGW-1:0]  i_idx,
    input  logic [WIDTH-1:0] i_rf_data,
    input  logic             i_exmem_we,
    input  logic [REGW-1:0]  i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_data,
    input  logic             i_memwb_we,
    input  logic [REGW-1:0]  i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_data,
    output logic [WIDTH-1:0] o_data
);

    // Register 0 is hard-wired to zero, so a pending write to it is never forwarded
    logic w_hit_exmem, w_hit_memwb;

    assign w_hit_exmem = i_exmem_we && i_exmem_rd != '0 && i_exmem_rd == i_idx;
    assign w_hit_memwb = i_memwb_we && i_memwb_rd != '0 && i_memwb_rd == i_idx;
    assign o_data      = w_hit_exmem ? i_exmem_data : w_hit_memwb ? i_memwb_data : i_rf_data;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage that decodes the ALU op, forwards operands and holds them in a one-entry valid/ready register
//   clk, reset                         clock, asynchronous active-high reset
//   in_valid/in_ready                  decode handshake
//   alu_op_in, funct                   ALUOp class and R-type function field
//   use_imm, imm                       select sign-extended immediate for i1
//   rs, rt, rs_data, rt_data           source indices and register-file data
//   exmem_*/memwb_*                    downstream write-backs used for forwarding
//   flush                              squash held and incoming instruction
//   out_valid/out_ready                execute handshake
//   i0, i1, op, illegal                registered ALU inputs and decode error flag
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op_in,
    input  logic [5:0]       funct,
    input  logic             use_imm,
    input  logic [15:0]      imm,
    input  logic [REGW-1:0]  rs,
    input  logic [REGW-1:0]  rt,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             exmem_we,
    input  logic             memwb_we,
    input  logic [REGW-1:0]  exmem_rd,
    input  logic [REGW-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic [WIDTH-1:0] memwb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] i0,
    output logic [WIDTH-1:0] i1,
    output logic [3:0]       op,
    output logic             illegal
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_i0, r_i1;
    logic [3:0]       r_op;
    logic             r_illegal;

    logic             w_capture;
    logic [WIDTH-1:0] w_fwd_a, w_fwd_b, w_i1;
    logic [3:0]       w_funct_op, w_op;
    logic             w_funct_ok, w_illegal;

    fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_a (
        .i_idx(rs), .i_rf_data(rs_data),
        .i_exmem_we(exmem_we), .i_exmem_rd(exmem_rd), .i_exmem_data(exmem_data),
        .i_memwb_we(memwb_we), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
        .o_data(w_fwd_a)
    );

    fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_b (
        .i_idx(rt), .i_rf_data(rt_data),
        .i_exmem_we(exmem_we), .i_exmem_rd(exmem_rd), .i_exmem_data(exmem_data),
        .i_memwb_we(memwb_we), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
        .o_data(w_fwd_b)
    );

    assign w_funct_op = funct == FUNCT_ADD ? ALU_ADD :
                        funct == FUNCT_SUB ? ALU_SUB :
                        funct == FUNCT_AND ? ALU_AND :
                        funct == FUNCT_OR  ? ALU_OR  :
                        funct == FUNCT_SLT ? ALU_SLT :
                        funct == FUNCT_NOR ? ALU_NOR : ALU_ADD;
    assign w_funct_ok = funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_NOR};
    assign w_op       = alu_op_in == ALUOP_ADD  ? ALU_ADD :
                        alu_op_in == ALUOP_SUB  ? ALU_SUB :
                        alu_op_in == ALUOP_SLTI ? ALU_SLT : w_funct_op;
    assign w_illegal  = alu_op_in == ALUOP_RTYPE && !w_funct_ok;
    assign w_i1       = use_imm ? {{(WIDTH-16){imm[15]}}, imm} : w_fwd_b;

    // Single entry without skid: accept only when empty or being drained this cycle
    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_i0        <= '0;
            r_i1        <= '0;
            r_op        <= ALU_ADD;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= flush ? 1'b0 : w_capture ? 1'b1 : out_ready ? 1'b0 : r_out_valid;
            if (w_capture) begin
                r_i0      <= w_fwd_a;
                r_i1      <= w_i1;
                r_op      <= w_op;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign i0        = r_i0;
    assign i1        = r_i1;
    assign op        = r_op;
    assign illegal   = r_illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue stage that drives the ALU's operand and op inputs (I0, I1, op). It does the following each time an instruction is captured from decode:
- translates ALUOp/funct into the 4-bit ALU op code;
- resolves operand forwarding from the EX/MEM and MEM/WB stages;
- selects the immediate;
- holds the result in a one-entry valid/ready pipeline register.

It sits between the register-file read and the ALU in the pipelined datapath.

Parameters:
WIDTH, 32, datapath/operand width
REGW, 5, register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
alu_op_in  input  2  00 add, 01 sub, 10 R-type (use funct), 11 slti
funct  input  6  R-type function field
use_imm  input  1  1: I1 = sign-extended imm
imm  input  16  immediate field
rs, rt  input  REGW each  source register indices
rs_data, rt_data  input  WIDTH each  register-file read data
exmem_we, memwb_we  input  1 each  downstream stages write a register
exmem_rd, memwb_rd  input  REGW each  downstream destination indices
exmem_data, memwb_data  input  WIDTH each  downstream result values
flush  input  1  squash held and incoming instruction
out_valid  output  1  I0/I1/op hold a valid instruction
out_ready  input  1  execute consumes this cycle
i0, i1  output  WIDTH each  ALU operands (registered)
op  output  4  ALU op code (registered)
illegal  output  1  registered; captured funct was not recognised

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, i0=0, i1=0, op=4'b0010, illegal=0.
- Ready and transfers:
  - in_ready = !out_valid || out_ready (combinational; one entry, no skid).
  - Capture occurs when in_valid && in_ready && !flush.
  - On capture: out_valid=1 next cycle; latency is 1 cycle from capture to outputs.
  - Drain with no capture: out_valid && out_ready && !(in_valid && in_ready) → out_valid=0 next cycle.
  - Simultaneous drain and capture: the new instruction replaces the old one and out_valid stays 1 (full throughput).
  - Not ready: out_valid && !out_ready → all outputs hold stable; in_ready=0.
- Flush:
  - flush=1 → out_valid=0 next cycle and no capture that cycle, regardless of in_valid/out_ready.
  - Data registers may hold their previous values.
- Op decode:
  - alu_op_in 00 → 0010 (add)
  - alu_op_in 01 → 0110 (sub)
  - alu_op_in 11 → 0111 (slti)
  - alu_op_in 10, decode funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
    - 100111 → 1100 (nor)
    - any other funct → op 0010, illegal=1.
  - illegal=0 for every other case.
- Forwarding (combinational, evaluated at capture), for operand A from rs:
  - if exmem_we && exmem_rd!=0 && exmem_rd==rs → exmem_data;
  - else if memwb_we && memwb_rd!=0 && memwb_rd==rs → memwb_data;
  - else rs_data.
  - Operand B from rt uses the same rule.
  - EX/MEM has priority when both stages match.
  - Register 0 is never forwarded.
- Operand select:
  - i0 = forwarded A.
  - use_imm=1 → i1 = {{WIDTH-16{imm[15]}}, imm}; the forwarded B value is ignored.
  - use_imm=0 → i1 = forwarded B.
- Reset mid-operation: the held instruction is discarded immediately; in_ready=1 while reset is deasserted and out_valid=0.

Decomposition:
- Shared package (alu_pkg), holding:
  - localparams for the six 4-bit ALU op codes;
  - localparams for the four ALUOp encodings;
  - localparams for the six funct codes.
  - The ALU and this stage both use these.
- Sub-module fwd_mux: purely combinational; inputs are index, rf data and both downstream we/rd/data; output is the forwarded value. It is instantiated twice (rs, rt).
- Decode and pipeline register stay in the top module.

Test Plan:
- Reset mid-stream: drive capture, assert reset between edges → out_valid=0, op=0010, i0=i1=0 immediately, without waiting for a clock edge.
- R-type decode sweep:
  - alu_op_in=10, funct=100100, rs_data=0xF0F0, rt_data=0x0FF0, out_ready=1 → next cycle op=0000, i0=0xF0F0, i1=0x0FF0, illegal=0.
  - funct=000011 → op=0010, illegal=1.
- Immediate sign-extension: alu_op_in=11, use_imm=1, imm=0xFFFE → op=0111, i1=0xFFFFFFFE.
- Forward priority:
  - rs=5, exmem_we=1, exmem_rd=5, exmem_data=0x11, memwb_we=1, memwb_rd=5, memwb_data=0x22 → i0=0x11.
  - exmem_rd=0, memwb_rd=0 with rs=0 → i0=rs_data.
- Backpressure:
  - out_valid=1, out_ready=0 for 3 cycles, in_valid=1 → in_ready=0; outputs unchanged.
  - Then out_ready=1 → new instruction appears on the next cycle with no bubble.
- Flush: in_valid=1, out_ready=1, flush=1 → out_valid=0 next cycle; the following instruction (flush=0) is captured normally.
